hazard_unit: RTL and testbench

Pipeline control block that consumes the ID/EX pipeline register outputs (destination register, source register addresses, memory-read flag) together with the EX/MEM and MEM/WB destination fields. It closes the loop back into the front end: it stalls PC and IF/ID on load-use hazards, flushes IF/ID, ID/EX and EX/MEM on taken branches, and selects ALU operand forwarding paths. A small post-flush state machine masks hazard detection, and saturating counters record stall and flush events for debug.

---
 rtl/hazard_unit_if.sv | 45 ++++
 rtl/hazard_unit.sv | 105 ++++++++++
 tb/tb_hazard_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit_if
// Description : Pipeline-register fields in, stall/flush/forward controls out.
// Revision    : 1.0
// ============================================================================
interface hazard_unit_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       idRs1;
    logic [4:0]       idRs2;
    logic [4:0]       exRs1;
    logic [4:0]       exRs2;
    logic [4:0]       exRd;
    logic             exMemRead;
    logic [4:0]       memRd;
    logic             memRegWrite;
    logic [4:0]       wbRd;
    logic             wbRegWrite;
    logic             branchTaken;
    logic             pcWrite;
    logic             ifidWrite;
    logic             ifidFlush;
    logic             idexFlush;
    logic             exmemFlush;
    logic [1:0]       fwdA;
    logic [1:0]       fwdB;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    modport master (
        output idRs1, idRs2, exRs1, exRs2, exRd, exMemRead,
               memRd, memRegWrite, wbRd, wbRegWrite, branchTaken,
        input  pcWrite, ifidWrite, ifidFlush, idexFlush, exmemFlush,
               fwdA, fwdB, stallCnt, flushCnt
    );

    modport slave (
        input  idRs1, idRs2, exRs1, exRs2, exRd, exMemRead,
               memRd, memRegWrite, wbRd, wbRegWrite, branchTaken,
        output pcWrite, ifidWrite, ifidFlush, idexFlush, exmemFlush,
               fwdA, fwdB, stallCnt, flushCnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Load-use stall, branch flush, operand forwarding, event counts.
// Revision    : 1.0
// ============================================================================
module hazard_unit #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  wire logic   clk,
    input  wire logic   reset,
    hazard_unit_if.slave bus
);
    localparam int               c_MASK_W    = $clog2(FLUSH_CYCLES + 1);
    localparam logic [c_MASK_W-1:0] c_MASK_LOAD = c_MASK_W'(FLUSH_CYCLES);
    localparam logic [c_MASK_W-1:0] c_MASK_ONE  = c_MASK_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_MASK = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_MASK_W-1:0] r_mask_cnt;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    logic w_load_use;
    logic w_stall;

    // MEM stage has priority over WB since it holds the younger result.
    function automatic logic [1:0] f_fwd(input logic [4:0] rs,
                                         input logic mem_we, input logic [4:0] mem_rd,
                                         input logic wb_we,  input logic [4:0] wb_rd);
        logic [1:0] sel;
        sel = 2'b00;
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs))
            sel = 2'b10;
        else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
            sel = 2'b01;
        return sel;
    endfunction

    assign w_load_use = bus.exMemRead && (bus.exRd != 5'd0) &&
                        ((bus.exRd == bus.idRs1) || (bus.exRd == bus.idRs2));
    assign w_stall    = w_load_use && (r_state == ST_RUN) && !bus.branchTaken;

    always_comb begin
        bus.pcWrite    = 1'b1;
        bus.ifidWrite  = 1'b1;
        bus.ifidFlush  = 1'b0;
        bus.idexFlush  = 1'b0;
        bus.exmemFlush = 1'b0;
        bus.fwdA       = f_fwd(bus.exRs1, bus.memRegWrite, bus.memRd, bus.wbRegWrite, bus.wbRd);
        bus.fwdB       = f_fwd(bus.exRs2, bus.memRegWrite, bus.memRd, bus.wbRegWrite, bus.wbRd);
        if (reset) begin
            bus.pcWrite    = 1'b0;
            bus.ifidWrite  = 1'b0;
            bus.ifidFlush  = 1'b1;
            bus.idexFlush  = 1'b1;
            bus.exmemFlush = 1'b1;
            bus.fwdA       = 2'b00;
            bus.fwdB       = 2'b00;
        end else if (bus.branchTaken) begin
            bus.ifidFlush  = 1'b1;
            bus.idexFlush  = 1'b1;
            bus.exmemFlush = 1'b1;
        end else if (w_stall) begin
            bus.pcWrite    = 1'b0;
            bus.ifidWrite  = 1'b0;
            bus.idexFlush  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_mask_cnt  <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (bus.branchTaken) begin
                r_state    <= ST_MASK;
                r_mask_cnt <= c_MASK_LOAD;
                if (r_flush_cnt != c_CNT_MAX)
                    r_flush_cnt <= r_flush_cnt + 1'b1;
            end else if (r_state == ST_MASK) begin
                if (r_mask_cnt <= c_MASK_ONE) begin
                    r_state    <= ST_RUN;
                    r_mask_cnt <= '0;
                end else begin
                    r_mask_cnt <= r_mask_cnt - 1'b1;
                end
            end
            if (w_stall && (r_stall_cnt != c_CNT_MAX))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.stallCnt = r_stall_cnt;
    assign bus.flushCnt = r_flush_cnt;
endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit
// Description : Directed and random checks of hazard_unit against a model.
// Revision    : 1.0
// ============================================================================
module tb_hazard_unit;
    localparam int FC   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    // Reference state: masked cycles still to run, and event totals.
    int m_mask_left = 0;
    int m_stalls    = 0;
    int m_flushes   = 0;

    hazard_unit_if #(.CNT_W(CW)) bus ();

    hazard_unit #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sel_of(input int rs);
        if (bus.memRegWrite && bus.memRd != 0 && bus.memRd == rs) return 2;
        if (bus.wbRegWrite && bus.wbRd != 0 && bus.wbRd == rs) return 1;
        return 0;
    endfunction

    function automatic bit model_stall();
        bit lu;
        lu = bus.exMemRead && bus.exRd != 0 &&
             (bus.exRd == bus.idRs1 || bus.exRd == bus.idRs2);
        return lu && (m_mask_left == 0) && !bus.branchTaken;
    endfunction

    task automatic set_in(input int id1, input int id2, input int ex1, input int ex2,
                          input int exrd, input bit mr, input int mrd, input bit mwe,
                          input int wrd, input bit wwe, input bit br);
        bus.idRs1 = 5'(id1);  bus.idRs2 = 5'(id2);
        bus.exRs1 = 5'(ex1);  bus.exRs2 = 5'(ex2);
        bus.exRd  = 5'(exrd); bus.exMemRead = mr;
        bus.memRd = 5'(mrd);  bus.memRegWrite = mwe;
        bus.wbRd  = 5'(wrd);  bus.wbRegWrite = wwe;
        bus.branchTaken = br;
    endtask

    // Checks the current cycle's outputs, then clocks and advances the model.
    task automatic step();
        bit st;
        bit br;
        #1;
        st = model_stall();
        br = bus.branchTaken;
        chk("pcWrite",    32'(bus.pcWrite),    32'(!st));
        chk("ifidWrite",  32'(bus.ifidWrite),  32'(!st));
        chk("ifidFlush",  32'(bus.ifidFlush),  32'(br));
        chk("idexFlush",  32'(bus.idexFlush),  32'(br || st));
        chk("exmemFlush", 32'(bus.exmemFlush), 32'(br));
        chk("fwdA",       32'(bus.fwdA),       32'(sel_of(bus.exRs1)));
        chk("fwdB",       32'(bus.fwdB),       32'(sel_of(bus.exRs2)));
        chk("stallCnt",   32'(bus.stallCnt),   32'(m_stalls));
        chk("flushCnt",   32'(bus.flushCnt),   32'(m_flushes));
        @(posedge clk);
        if (br) begin
            m_mask_left = FC;
            if (m_flushes < CMAX) m_flushes++;
        end else if (m_mask_left > 0) begin
            m_mask_left--;
        end
        if (st && m_stalls < CMAX) m_stalls++;
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc"},   32'(bus.pcWrite),    32'd0);
        chk({tag, "_ifid"}, 32'(bus.ifidWrite),  32'd0);
        chk({tag, "_fl"},   32'({bus.ifidFlush, bus.idexFlush, bus.exmemFlush}), 32'd7);
        chk({tag, "_fwd"},  32'({bus.fwdA, bus.fwdB}), 32'd0);
        chk({tag, "_cnt"},  32'({bus.stallCnt, bus.flushCnt}), 32'd0);
    endtask

    initial begin
        // Reset with inputs that would otherwise stall and forward.
        set_in(5, 5, 7, 7, 5, 1, 7, 1, 7, 1, 0);
        #2;
        chk_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Load then dependent use: one bubble, then normal flow.
        set_in(1, 5, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        #1 chk("lu_pcWrite", 32'(bus.pcWrite), 32'd0);
        step();
        set_in(1, 5, 0, 5, 9, 0, 5, 1, 0, 0, 0);
        step();
        chk("lu_stallCnt", 32'(bus.stallCnt), 32'd1);

        // x0 sources never stall.
        set_in(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step();

        // Branch masks load-use for FC cycles, then the stall happens.
        set_in(3, 4, 0, 0, 3, 1, 0, 0, 0, 0, 1);
        step();
        bus.branchTaken = 1'b0;
        for (int i = 0; i < FC + 1; i++) step();
        chk("br_flushCnt", 32'(bus.flushCnt), 32'd1);

        // Forwarding priority cases.
        set_in(0, 0, 7, 7, 0, 0, 7, 1, 7, 1, 0);
        #1 chk("fwd_mem", 32'(bus.fwdA), 32'd2);
        step();
        bus.memRegWrite = 1'b0;
        #1 chk("fwd_wb", 32'(bus.fwdA), 32'd1);
        step();
        bus.exRs1 = 5'd0; bus.memRd = 5'd0; bus.memRegWrite = 1'b1;
        step();

        // Reset during MASK, then detection resumes immediately.
        set_in(6, 6, 0, 0, 6, 1, 0, 0, 0, 0, 1);
        step();
        bus.branchTaken = 1'b0;
        reset = 1'b1;
        #1 chk_reset_outputs("midmask");
        m_mask_left = 0; m_stalls = 0; m_flushes = 0;
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("resume_stall", 32'(bus.stallCnt), 32'd1);

        // Drive the stall counter into saturation.
        for (int i = 0; i < CMAX + 3; i++) begin
            set_in(8, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0);
            step();
        end
        chk("sat_stall", 32'(bus.stallCnt), 32'(CMAX));

        // Random traffic over a small register range so matches are common.
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
